// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: issues one load/store per instruction on a split
// address/data handshake bus, aligns load data and registers the MEM/WB fields.
module mem_lsu #(
    parameter int ALE_BIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_inst_valid_i,
    input  logic [31:0] mem_inst_pc_i,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_reg2_i,
    input  logic        excp_i,
    input  logic [9:0]  excp_num_i,
    output logic        data_req,
    output logic        data_we,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stallreq,
    output logic        wb_inst_valid,
    output logic [31:0] wb_inst_pc,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        excp_o,
    output logic [9:0]  excp_num_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [9:0] ALE_MASK = 10'd1 << ALE_BIT;

    state_t      r_state;
    state_t      w_nextState;

    logic        w_isLoad;
    logic        w_isStore;
    logic        w_isHalf;
    logic        w_isWord;
    logic        w_isSigned;
    logic        w_mis;
    logic        w_acc;
    logic        w_ale;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;
    logic [31:0] w_wbData;

    always_comb begin
        w_isLoad   = 1'b0;
        w_isStore  = 1'b0;
        w_isHalf   = 1'b0;
        w_isWord   = 1'b0;
        w_isSigned = 1'b0;
        case (mem_op_i)
            4'd1: begin w_isLoad = 1'b1; w_isSigned = 1'b1; end
            4'd2: begin w_isLoad = 1'b1; w_isSigned = 1'b1; w_isHalf = 1'b1; end
            4'd3: begin w_isLoad = 1'b1; w_isWord = 1'b1; end
            4'd4: w_isLoad = 1'b1;
            4'd5: begin w_isLoad = 1'b1; w_isHalf = 1'b1; end
            4'd6: w_isStore = 1'b1;
            4'd7: begin w_isStore = 1'b1; w_isHalf = 1'b1; end
            4'd8: begin w_isStore = 1'b1; w_isWord = 1'b1; end
            default: ;
        endcase
    end

    assign w_mis = (w_isHalf & mem_addr_i[0]) | (w_isWord & (mem_addr_i[1:0] != 2'b00));
    assign w_acc = mem_inst_valid_i & (w_isLoad | w_isStore) & ~excp_i & ~w_mis;
    assign w_ale = mem_inst_valid_i & (w_isLoad | w_isStore) & w_mis;

    // Store lanes are replicated so the strobes alone select the written bytes.
    always_comb begin
        data_we    = w_isStore;
        data_addr  = mem_addr_i;
        data_wstrb = 4'b0000;
        data_wdata = mem_reg2_i;
        case (mem_op_i)
            4'd6: begin
                data_wstrb = 4'b0001 << mem_addr_i[1:0];
                data_wdata = {4{mem_reg2_i[7:0]}};
            end
            4'd7: begin
                data_wstrb = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{mem_reg2_i[15:0]}};
            end
            4'd8: data_wstrb = 4'b1111;
            default: ;
        endcase
    end

    assign w_byte = data_rdata[{mem_addr_i[1:0], 3'b000} +: 8];
    assign w_half = data_rdata[{mem_addr_i[1], 4'b0000} +: 16];

    always_comb begin
        if (w_isWord)
            w_loadData = data_rdata;
        else if (w_isHalf)
            w_loadData = {{16{w_isSigned & w_half[15]}}, w_half};
        else
            w_loadData = {{24{w_isSigned & w_byte[7]}}, w_byte};
    end

    assign w_wbData = (w_isLoad & w_acc) ? w_loadData : mem_wdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    // A response arriving together with a flush in WAIT is simply consumed; the
    // flush already kills the write-back, so there is nothing left to drain.
    always_comb begin
        w_nextState = r_state;
        data_req    = 1'b0;
        stallreq    = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_req = w_acc & ~flush;
                stallreq = w_acc & ~flush & ~(data_addr_ok & data_data_ok);
                if (data_req & data_addr_ok & ~data_data_ok)
                    w_nextState = S_WAIT;
            end
            S_WAIT: begin
                stallreq = ~data_data_ok & ~flush;
                if (data_data_ok)
                    w_nextState = S_IDLE;
                else if (flush)
                    w_nextState = S_DRAIN;
            end
            S_DRAIN: begin
                stallreq = w_acc;
                if (data_data_ok)
                    w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Bubbles also clear the exception fields so a stalled cycle never re-raises
    // the previous instruction's exception in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_inst_valid <= 1'b0;
            wb_inst_pc    <= 32'd0;
            wb_wd         <= 5'd0;
            wb_wreg       <= 1'b0;
            wb_wdata      <= 32'd0;
            excp_o        <= 1'b0;
            excp_num_o    <= 10'd0;
        end else if (flush) begin
            wb_inst_valid <= 1'b0;
            wb_wreg       <= 1'b0;
            excp_o        <= 1'b0;
            excp_num_o    <= 10'd0;
        end else if (!stallreq) begin
            wb_inst_valid <= mem_inst_valid_i;
            wb_inst_pc    <= mem_inst_pc_i;
            wb_wd         <= mem_wd_i;
            wb_wreg       <= mem_wreg_i;
            wb_wdata      <= w_wbData;
            excp_o        <= excp_i | w_ale;
            excp_num_o    <= excp_num_i | (w_ale ? ALE_MASK : 10'd0);
        end else begin
            wb_inst_valid <= 1'b0;
            wb_wreg       <= 1'b0;
            excp_o        <= 1'b0;
            excp_num_o    <= 10'd0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized transactions
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_inst_valid_i;
    logic [31:0] mem_inst_pc_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_reg2_i;
    logic        excp_i;
    logic [9:0]  excp_num_i;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stallreq;
    logic        wb_inst_valid;
    logic [31:0] wb_inst_pc;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        excp_o;
    logic [9:0]  excp_num_o;

    int errors = 0;
    int checks = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_inst_valid_i(mem_inst_valid_i), .mem_inst_pc_i(mem_inst_pc_i),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .excp_i(excp_i), .excp_num_i(excp_num_i),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stallreq(stallreq),
        .wb_inst_valid(wb_inst_valid), .wb_inst_pc(wb_inst_pc), .wb_wd(wb_wd),
        .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .excp_o(excp_o), .excp_num_o(excp_num_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference load result: pick the lane by byte offset, then extend.
    function automatic logic [31:0] loadModel(input int op, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            2: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3: return rdata;
            4: return b;
            default: return h;
        endcase
    endfunction

    task automatic idleInputs();
        mem_inst_valid_i = 1'b0;
        mem_op_i         = 4'd0;
        mem_wreg_i       = 1'b0;
        excp_i           = 1'b0;
        data_addr_ok     = 1'b0;
        data_data_ok     = 1'b0;
        flush            = 1'b0;
    endtask

    // One instruction with bus acks after aD cycles (addr_ok) and aD+dD (data_ok).
    task automatic applyStimulus(input int op, input logic [31:0] addr, input logic [31:0] pc,
                                 input logic [4:0] wd, input logic [31:0] wdata,
                                 input logic [31:0] reg2, input logic [9:0] eNum,
                                 input logic [31:0] rdata, input int aD, input int dD);
        bit isMem, isLoad, isStore, isH, isW, mis, acc;
        logic [31:0] expWb, expStrb, expBusData;
        logic [9:0]  expNum;
        int total;
        isMem   = (op >= 1 && op <= 8);
        isLoad  = (op >= 1 && op <= 5);
        isStore = (op >= 6 && op <= 8);
        isH     = (op == 2 || op == 5 || op == 7);
        isW     = (op == 3 || op == 8);
        mis     = isMem && ((isH && (addr % 2 != 0)) || (isW && (addr % 4 != 0)));
        acc     = isMem && !mis;
        expWb   = (acc && isLoad) ? loadModel(op, addr, rdata) : wdata;
        expNum  = mis ? (eNum | 10'd256) : eNum;
        expStrb = 0;
        expBusData = reg2;
        if (op == 6) begin
            expStrb = 1 << (addr % 4);
            expBusData = (reg2 & 255) * 32'h0101_0101;
        end else if (op == 7) begin
            expStrb = 3 << (2 * ((addr / 2) % 2));
            expBusData = (reg2 & 65535) * 32'h0001_0001;
        end else if (op == 8) begin
            expStrb = 15;
        end
        total = acc ? aD + dD : 0;

        mem_inst_valid_i = 1'b1;
        mem_op_i         = 4'(op);
        mem_addr_i       = addr;
        mem_inst_pc_i    = pc;
        mem_wd_i         = wd;
        mem_wreg_i       = 1'b1;
        mem_wdata_i      = wdata;
        mem_reg2_i       = reg2;
        excp_i           = 1'b0;
        excp_num_i       = eNum;
        for (int c = 0; c <= total; c++) begin
            data_addr_ok = acc && (c == aD);
            data_data_ok = acc && (c == total);
            data_rdata   = (c == total) ? rdata : $urandom;
            #3;
            checkOutput("data_req", data_req, acc && (c <= aD));
            if (acc && c <= aD) begin
                checkOutput("data_addr", data_addr, addr);
                checkOutput("data_we", data_we, isStore);
                checkOutput("data_wstrb", data_wstrb, expStrb);
                if (isStore) checkOutput("data_wdata", data_wdata, expBusData);
            end
            checkOutput("stallreq", stallreq, acc && (c < total));
            nextCycle();
            if (c < total) checkOutput("bubble_valid", wb_inst_valid, 0);
        end
        idleInputs();
        checkOutput("wb_valid", wb_inst_valid, 1);
        checkOutput("wb_pc", wb_inst_pc, pc);
        checkOutput("wb_wd", wb_wd, wd);
        checkOutput("wb_wreg", wb_wreg, 1);
        checkOutput("wb_wdata", wb_wdata, expWb);
        checkOutput("excp_o", excp_o, mis);
        checkOutput("excp_num_o", excp_num_o, expNum);
    endtask

    initial begin
        int op;
        logic [31:0] addr;

        rst = 1'b1;
        idleInputs();
        mem_inst_pc_i = 0; mem_wd_i = 0; mem_wdata_i = 0; mem_addr_i = 0;
        mem_reg2_i = 0; excp_num_i = 0; data_rdata = 0;
        #2;
        checkOutput("rst_wb_valid", wb_inst_valid, 0);
        checkOutput("rst_wb_wdata", wb_wdata, 0);
        checkOutput("rst_excp_num", excp_num_o, 0);
        checkOutput("rst_stallreq", stallreq, 0);
        checkOutput("rst_data_req", data_req, 0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("[TB] ADD passthrough");
        applyStimulus(0, 32'h0, 32'h1C00_0000, 5'd5, 32'h1234, 32'h0, 10'd0, 32'h0, 0, 0);

        $display("[TB] LD.B / LD.BU sign and zero extension");
        applyStimulus(1, 32'h1003, 32'h1C00_0004, 5'd6, 32'h1003, 32'h0, 10'd0, 32'h80FF_FF7F, 0, 2);
        checkOutput("ldb_const", wb_wdata, 32'hFFFF_FF80);
        applyStimulus(4, 32'h1003, 32'h1C00_0008, 5'd7, 32'h1003, 32'h0, 10'd0, 32'h80FF_FF7F, 0, 2);
        checkOutput("ldbu_const", wb_wdata, 32'h0000_0080);

        $display("[TB] ST.H with late addr_ok");
        applyStimulus(7, 32'h2002, 32'h1C00_000C, 5'd0, 32'h2002, 32'hAAAA_BEEF, 10'd0, 32'h0, 3, 1);

        $display("[TB] misaligned LD.W");
        applyStimulus(3, 32'h3001, 32'h1C00_0010, 5'd8, 32'h3001, 32'h0, 10'd0, 32'h0, 0, 0);
        checkOutput("ale_bit", 32'(excp_num_o[8]), 1);

        $display("[TB] flush in WAIT then LD.H during drain");
        mem_inst_valid_i = 1'b1; mem_op_i = 4'd3; mem_addr_i = 32'h4000;
        mem_inst_pc_i = 32'h1C00_0014; mem_wd_i = 5'd9; mem_wreg_i = 1'b1;
        data_addr_ok = 1'b1;
        #3;
        checkOutput("fl_req0", data_req, 1);
        nextCycle();
        data_addr_ok = 1'b0; flush = 1'b1;
        #3;
        checkOutput("fl_stall1", stallreq, 0);
        checkOutput("fl_req1", data_req, 0);
        nextCycle();
        checkOutput("fl_wb1", wb_inst_valid, 0);
        flush = 1'b0; mem_op_i = 4'd2; mem_addr_i = 32'h5002;
        mem_inst_pc_i = 32'h1C00_0040; mem_wd_i = 5'd10;
        #3;
        checkOutput("dr_req2", data_req, 0);
        checkOutput("dr_stall2", stallreq, 1);
        nextCycle();
        checkOutput("dr_wb2", wb_inst_valid, 0);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #3;
        checkOutput("dr_req3", data_req, 0);
        checkOutput("dr_stall3", stallreq, 1);
        nextCycle();
        checkOutput("dr_wb3", wb_inst_valid, 0);
        data_data_ok = 1'b0; data_addr_ok = 1'b1;
        #3;
        checkOutput("ldh_req4", data_req, 1);
        checkOutput("ldh_addr4", data_addr, 32'h5002);
        checkOutput("ldh_stall4", stallreq, 1);
        nextCycle();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8001_0000;
        #3;
        checkOutput("ldh_stall5", stallreq, 0);
        nextCycle();
        idleInputs();
        checkOutput("ldh_valid", wb_inst_valid, 1);
        checkOutput("ldh_pc", wb_inst_pc, 32'h1C00_0040);
        checkOutput("ldh_wdata", wb_wdata, 32'hFFFF_8001);

        $display("[TB] reset during WAIT");
        applyStimulus(0, 32'h0, 32'h1C00_0050, 5'd3, 32'hCAFE_0000, 32'h0, 10'd0, 32'h0, 0, 0);
        mem_inst_valid_i = 1'b1; mem_op_i = 4'd3; mem_addr_i = 32'h6000;
        mem_inst_pc_i = 32'h1C00_0054; mem_wreg_i = 1'b1; data_addr_ok = 1'b1;
        nextCycle();
        data_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rw_wdata", wb_wdata, 0);
        checkOutput("rw_pc", wb_inst_pc, 0);
        checkOutput("rw_req_idle", data_req, 1);
        idleInputs();
        #1;
        rst = 1'b0;
        nextCycle();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #3;
        checkOutput("late_req", data_req, 0);
        checkOutput("late_stall", stallreq, 0);
        nextCycle();
        data_data_ok = 1'b0;
        checkOutput("late_valid", wb_inst_valid, 0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == 2 || op == 5 || op == 7) addr[0] = 1'b0;
                if (op == 3 || op == 8) addr[1:0] = 2'b00;
            end
            applyStimulus(op, addr, $urandom, 5'($urandom), $urandom, $urandom,
                          10'($urandom), $urandom, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
